ps2_key_tracker: RTL and testbench

Parametrised PS/2 scan-code tracker that turns the raw byte stream from the keyboard interface into a held/released state vector for a configurable set of keys. It decodes make, break (F0) and extended (E0) sequences, so paddle controls stop when a key is released instead of latching the last key. It sits between `PS2_Interface` (scan-code byte plus strobe) and the game/VGA logic, replacing per-key equality decodes.

---
 rtl/ps2_key_tracker.sv | 163 ++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: turns the PS/2 set-2 scan-code byte stream into held/released
// state for a configurable table of keys. It decodes the make, break (F0) and
// extended (E0) sequences. A prefix that is left hanging is abandoned after
// TIMEOUT_CYCLES idle cycles.
//
// Input handshake: ps2_key_pressed is a one-cycle strobe with no back-pressure.
// ps2_key_data is sampled only in a cycle where ps2_key_pressed = 1, and every
// strobe is consumed, including back-to-back strobes.
//
// fsm_state exposes the parser state for observation:
// 0 = IDLE, 1 = EXT, 2 = BRK, 3 = EXT_BRK.
module ps2_key_tracker #(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = 32'h42_44_1B_1D,
    parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 4'b0000,
    parameter int                    TIMEOUT_CYCLES = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          ps2_key_data,
    input  logic                ps2_key_pressed,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_make,
    output logic [NUM_KEYS-1:0] key_break,
    output logic                seq_error,
    output logic [1:0]          fsm_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXT     = 2'd1;
    localparam logic [1:0] BRK     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT_CYCLES);

    localparam logic [7:0] BYTE_EXT     = 8'hE0;
    localparam logic [7:0] BYTE_BREAK   = 8'hF0;
    localparam logic [7:0] BYTE_OVR_LO  = 8'h00;
    localparam logic [7:0] BYTE_OVR_HI  = 8'hFF;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] down_q, down_d;
    logic [NUM_KEYS-1:0] make_q, make_d;
    logic [NUM_KEYS-1:0] break_q, break_d;
    logic                err_q, err_d;

    logic [NUM_KEYS-1:0] code_hit;
    logic [NUM_KEYS-1:0] hit;
    logic                ev_make;
    logic                ev_break;
    logic                ev_ext;

    // Compare the incoming byte against every table slot.
    // The extended flag then selects which of those hits count.
    always_comb begin
        code_hit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            code_hit[i] = (ps2_key_data == KEY_CODES[8*i +: 8]);
        end
        hit = ev_ext ? (code_hit & KEY_EXT) : (code_hit & ~KEY_EXT);
    end

    // Parser, timeout counter and key-state next-value logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        down_d   = down_q;
        make_d   = '0;
        break_d  = '0;
        err_d    = 1'b0;
        ev_make  = 1'b0;
        ev_break = 1'b0;
        ev_ext   = 1'b0;

        if (ps2_key_pressed) begin
            // A strobe always restarts the idle count.
            // It also takes priority over a timeout that would fire in the same cycle.
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (ps2_key_data == BYTE_EXT) begin
                        state_d = EXT;
                    end else if (ps2_key_data == BYTE_BREAK) begin
                        state_d = BRK;
                    end else if (ps2_key_data == BYTE_OVR_LO || ps2_key_data == BYTE_OVR_HI) begin
                        // On keyboard overrun, release everything so no key stays stuck.
                        down_d  = '0;
                        break_d = down_q;
                        err_d   = 1'b1;
                    end else begin
                        ev_make = 1'b1;
                    end
                end
                EXT: begin
                    if (ps2_key_data == BYTE_BREAK) begin
                        state_d = EXT_BRK;
                    end else if (ps2_key_data != BYTE_EXT) begin
                        ev_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    ev_break = 1'b1;
                    state_d  = IDLE;
                end
                default: begin
                    ev_break = 1'b1;
                    ev_ext   = 1'b1;
                    state_d  = IDLE;
                end
            endcase
        end else if (state_q != IDLE) begin
            if (cnt_q == CNT_LAST) begin
                // Abandon the stalled prefix. Held keys are left untouched.
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // A typematic repeat on a held key does not produce a new make pulse.
        // A break on a released key is silent.
        if (ev_make) begin
            down_d = down_q | hit;
            make_d = hit & ~down_q;
        end else if (ev_break) begin
            down_d  = down_q & ~hit;
            break_d = hit & down_q;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            down_q  <= '0;
            make_q  <= '0;
            break_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            down_q  <= down_d;
            make_q  <= make_d;
            break_q <= break_d;
            err_q   <= err_d;
        end
    end

    assign key_down  = down_q;
    assign key_make  = make_q;
    assign key_break = break_q;
    assign seq_error = err_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker. Two instances are driven by one byte stream:
// - dut0 uses the default key table.
// - dut1 moves slot 0 to the extended up-arrow (E0 75).
// A sequence-level reference model pushes the expected outputs for each cycle.
// A negedge monitor pops those values and compares them with the DUT outputs.
module tb_ps2_key_tracker;

    localparam int T = 12;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       strobe;

    logic [3:0] down0, make0, brk0, down1, make1, brk1;
    logic       err0, err1;
    logic [1:0] st0, st1;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [13:0] exp_q0[$];
    logic [13:0] exp_q1[$];

    ps2_key_tracker #(
        .NUM_KEYS(4), .KEY_CODES(32'h42_44_1B_1D), .KEY_EXT(4'b0000), .TIMEOUT_CYCLES(T)
    ) dut0 (
        .clock(clk), .reset(rst), .ps2_key_data(data), .ps2_key_pressed(strobe),
        .key_down(down0), .key_make(make0), .key_break(brk0),
        .seq_error(err0), .fsm_state(st0)
    );

    ps2_key_tracker #(
        .NUM_KEYS(4), .KEY_CODES(32'h42_44_1B_75), .KEY_EXT(4'b0001), .TIMEOUT_CYCLES(T)
    ) dut1 (
        .clock(clk), .reset(rst), .ps2_key_data(data), .ps2_key_pressed(strobe),
        .key_down(down1), .key_make(make1), .key_break(brk1),
        .seq_error(err1), .fsm_state(st1)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- reference model ----------------
    logic [7:0] codes[2][4];
    logic [3:0] ext_m[2];
    bit         pend_e0[2];
    bit         pend_f0[2];
    int         idle_cnt[2];
    logic [3:0] down_m[2];

    initial begin
        codes[0][0] = 8'h1D; codes[0][1] = 8'h1B; codes[0][2] = 8'h44; codes[0][3] = 8'h42;
        codes[1][0] = 8'h75; codes[1][1] = 8'h1B; codes[1][2] = 8'h44; codes[1][3] = 8'h42;
        ext_m[0] = 4'b0000;
        ext_m[1] = 4'b0001;
    end

    always @(posedge clk) begin
        logic [3:0] mk, bk, hit;
        logic       er;
        for (int d = 0; d < 2; d++) begin
            mk = '0; bk = '0; er = 1'b0; hit = '0;
            if (rst) begin
                pend_e0[d] = 0; pend_f0[d] = 0; idle_cnt[d] = 0; down_m[d] = '0;
            end else if (strobe) begin
                idle_cnt[d] = 0;
                if (!pend_e0[d] && !pend_f0[d] && (data == 8'h00 || data == 8'hFF)) begin
                    bk = down_m[d];
                    down_m[d] = '0;
                    er = 1'b1;
                end else if (!pend_f0[d] && data == 8'hE0) begin
                    pend_e0[d] = 1;
                end else if (!pend_f0[d] && data == 8'hF0) begin
                    pend_f0[d] = 1;
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (codes[d][k] == data && ext_m[d][k] == pend_e0[d]) hit[k] = 1'b1;
                    if (pend_f0[d]) begin
                        bk = hit & down_m[d];
                        down_m[d] = down_m[d] & ~hit;
                    end else begin
                        mk = hit & ~down_m[d];
                        down_m[d] = down_m[d] | hit;
                    end
                    pend_e0[d] = 0; pend_f0[d] = 0;
                end
            end else if (pend_e0[d] || pend_f0[d]) begin
                idle_cnt[d]++;
                if (idle_cnt[d] == T) begin
                    pend_e0[d] = 0; pend_f0[d] = 0; idle_cnt[d] = 0; er = 1'b1;
                end
            end
            if (d == 0) exp_q0.push_back({!(pend_e0[d] || pend_f0[d]), er, bk, mk, down_m[d]});
            else        exp_q1.push_back({!(pend_e0[d] || pend_f0[d]), er, bk, mk, down_m[d]});
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [13:0] e, a;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            if (rst) e = {1'b1, 13'b0};
            a = {st0 == 2'd0, err0, brk0, make0, down0};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL dut0 outputs cycle %0d got idle/err/brk/make/down=%b want %b", cycle, a, e);
            end
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            if (rst) e = {1'b1, 13'b0};
            a = {st1 == 2'd0, err1, brk1, make1, down1};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL dut1 outputs cycle %0d got idle/err/brk/make/down=%b want %b", cycle, a, e);
            end
        end
    end

    // ---------------- driver tasks (start/end just after a posedge) ----------------
    task automatic send(input logic [7:0] b);
        data   = b;
        strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        data   = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] pool[12];

    initial begin
        pool = '{8'h1D, 8'h1B, 8'h44, 8'h42, 8'h75, 8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};
        rst = 1'b1; strobe = 1'b0; data = 8'h00;
        @(posedge clk); #1;
        idle(2);
        rst = 1'b0;
        idle(2);

        // basic make then break of W
        send(8'h1D); idle(2);
        send(8'hF0); send(8'h1D); idle(2);

        // W and O held with typematic repeats of W, then release
        send(8'h1D); send(8'h44); send(8'h1D); send(8'h1D); send(8'h1D); idle(2);
        send(8'hF0); send(8'h1D); send(8'hF0); send(8'h44); idle(2);

        // extended up-arrow against the plain code
        send(8'h75); idle(1);
        send(8'hE0); send(8'h75); idle(1);
        send(8'hE0); send(8'hF0); send(8'h75); idle(2);

        // timeout after F0, then the next byte is a make
        send(8'hF0); idle(T); send(8'h1B); idle(2);
        // strobe in the last idle cycle wins over the timeout
        send(8'hF0); idle(T - 1); send(8'h1B); idle(2);
        // timeouts from the E0 and E0 F0 prefixes
        send(8'hE0); idle(T + 3);
        send(8'hE0); send(8'hF0); idle(T); idle(2);

        // overrun releases W and K together
        send(8'h1D); send(8'h42); idle(1); send(8'hFF); idle(2);

        // reset in the middle of a break sequence
        send(8'hF0); do_reset(2); send(8'h1D); idle(2);
        send(8'hF0); send(8'h1D); idle(1);

        // random byte stream with random gaps, some near the timeout
        for (int n = 0; n < 400; n++) begin
            send(pool[$urandom_range(0, 11)]);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(T - 2, T + 2));
            else                           idle($urandom_range(0, 2));
            if ($urandom_range(0, 199) == 0) do_reset(1);
        end

        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Upper bound on run time.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
